// File: rtl/seq_mac_unit_pkg.sv
// rtl/seq_mac_unit_pkg.sv - shared state encoding and parameter legality helper for seq_mac_unit
package seq_mac_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } mac_state_t;

  function automatic bit step_legal(input int width, input int step);
    return ((step == 1) || (step == 2) || (step == 4)) && ((width % step) == 0);
  endfunction

endpackage

// File: rtl/seq_mac_unit_mac_step_pp.sv
// rtl/seq_mac_unit_mac_step_pp.sv - one STEP-bit digit of the shift-add partial product
module mac_step_pp #(
  parameter int WIDTH = 16,
  parameter int STEP  = 1,
  parameter int CW    = 5
) (
  input  logic [WIDTH-1:0]   mag_b,
  input  logic [STEP-1:0]    digit,
  input  logic [CW-1:0]      count,
  output logic [2*WIDTH-1:0] pp
);

  logic [2*WIDTH-1:0] prod;

  always_comb begin
    prod = (2*WIDTH)'(mag_b) * (2*WIDTH)'(digit);
    pp   = prod << (int'(count) * STEP);
  end

endmodule

// File: rtl/seq_mac_unit.sv
// rtl/seq_mac_unit.sv - sequential shift-add multiply/accumulate with start/busy/done handshake
// Operates on magnitudes and applies the sign once in FIX, so signed and unsigned share one datapath.
module seq_mac_unit
  import seq_mac_unit_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int STEP  = 1
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  input  logic               start,
  input  logic               abort,
  input  logic               is_signed,
  input  logic               accumulate,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] result
);

  localparam int N  = WIDTH / STEP;
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  generate
    if (!step_legal(WIDTH, STEP)) begin : g_bad_step
      $error("seq_mac_unit: STEP must be 1, 2 or 4 and divide WIDTH");
    end
  endgenerate

  mac_state_t         state;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic               sign_q;
  logic               acc_q;
  logic [CW-1:0]      count;
  logic [2*WIDTH-1:0] partial;
  logic [2*WIDTH-1:0] pp;
  logic [2*WIDTH-1:0] signed_p;
  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;

  mac_step_pp #(
    .WIDTH (WIDTH),
    .STEP  (STEP),
    .CW    (CW)
  ) u_pp (
    .mag_b (mag_b),
    .digit (mag_a[STEP-1:0]),
    .count (count),
    .pp    (pp)
  );

  // Negating the most negative value wraps back to 2^(W-1), which is the correct unsigned magnitude.
  always_comb begin
    abs_a    = (is_signed && op_a[WIDTH-1]) ? (~op_a + 1'b1) : op_a;
    abs_b    = (is_signed && op_b[WIDTH-1]) ? (~op_b + 1'b1) : op_b;
    signed_p = sign_q ? (~partial + 1'b1) : partial;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state   <= ST_IDLE;
      mag_a   <= '0;
      mag_b   <= '0;
      sign_q  <= 1'b0;
      acc_q   <= 1'b0;
      count   <= '0;
      partial <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start && !abort) begin
            mag_a   <= abs_a;
            mag_b   <= abs_b;
            sign_q  <= is_signed & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
            acc_q   <= accumulate;
            count   <= '0;
            partial <= '0;
            busy    <= 1'b1;
            state   <= ST_CALC;
          end
        end
        ST_CALC: begin
          if (abort) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            partial <= partial + pp;
            mag_a   <= mag_a >> STEP;
            count   <= count + 1'b1;
            if (count == LAST) state <= ST_FIX;
          end
        end
        ST_FIX: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
          if (!abort) begin
            result <= acc_q ? (result + signed_p) : signed_p;
            done   <= 1'b1;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mac_unit.sv
// tb/tb_seq_mac_unit.sv - self-checking bench for seq_mac_unit (STEP=1 and STEP=4 instances)
module tb_seq_mac_unit;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        is_signed = 1'b0;
  logic        accumulate = 1'b0;
  logic [15:0] op_a = '0;
  logic [15:0] op_b = '0;
  logic        sel4 = 1'b0;

  logic        start1, start4;
  logic        busy1, done1, busy4, done4;
  logic [31:0] result1, result4;
  logic        cur_busy, cur_done;
  logic [31:0] cur_result;

  logic [31:0] model1 = '0;
  logic [31:0] model4 = '0;
  int checks = 0;
  int errors = 0;

  always #5 sys_clk = ~sys_clk;

  assign start1     = start & ~sel4;
  assign start4     = start & sel4;
  assign cur_busy   = sel4 ? busy4 : busy1;
  assign cur_done   = sel4 ? done4 : done1;
  assign cur_result = sel4 ? result4 : result1;

  seq_mac_unit #(.WIDTH(16), .STEP(1)) u_dut1 (
    .sys_clk (sys_clk), .sys_rst (sys_rst), .start (start1), .abort (abort),
    .is_signed (is_signed), .accumulate (accumulate), .op_a (op_a), .op_b (op_b),
    .busy (busy1), .done (done1), .result (result1)
  );

  seq_mac_unit #(.WIDTH(16), .STEP(4)) u_dut4 (
    .sys_clk (sys_clk), .sys_rst (sys_rst), .start (start4), .abort (abort),
    .is_signed (is_signed), .accumulate (accumulate), .op_a (op_a), .op_b (op_b),
    .busy (busy4), .done (done4), .result (result4)
  );

  function automatic logic [31:0] ref_mac(input logic [31:0] prev, input logic [15:0] a,
                                          input logic [15:0] b, input logic s, input logic acc);
    longint av, bv, p;
    av = s ? longint'($signed(a)) : longint'({48'b0, a});
    bv = s ? longint'($signed(b)) : longint'({48'b0, b});
    p  = av * bv;
    return acc ? (prev + p[31:0]) : p[31:0];
  endfunction

  task automatic cycle();
    @(posedge sys_clk);
    @(negedge sys_clk);
  endtask

  task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic s,
                       input logic acc, input int exp_lat, input string name);
    logic [31:0] exp_r;
    int lat;
    exp_r = ref_mac(sel4 ? model4 : model1, a, b, s, acc);
    op_a = a; op_b = b; is_signed = s; accumulate = acc; start = 1'b1;
    cycle();
    start = 1'b0;
    checks++;
    if (cur_busy !== 1'b1) begin
      errors++; $display("FAIL %s_busy got %b want 1", name, cur_busy);
    end
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      cycle();
      if (cur_done === 1'b1) begin lat = i; break; end
    end
    checks++;
    if (lat != exp_lat) begin
      errors++; $display("FAIL %s_latency got %0d want %0d", name, lat, exp_lat);
    end
    checks++;
    if (cur_result !== exp_r) begin
      errors++; $display("FAIL %s_result got %h want %h", name, cur_result, exp_r);
    end
    checks++;
    if (cur_busy !== 1'b0) begin
      errors++; $display("FAIL %s_busy_at_done got %b want 0", name, cur_busy);
    end
    if (sel4) model4 = exp_r; else model1 = exp_r;
    cycle();
    checks++;
    if (cur_done !== 1'b0) begin
      errors++; $display("FAIL %s_done_width got %b want 0", name, cur_done);
    end
  endtask

  task automatic count_dones(input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      cycle();
      if (cur_done === 1'b1) cnt++;
    end
  endtask

  task automatic test_reset();
    int cnt;
    sys_rst = 1'b1;
    cycle(); cycle();
    sys_rst = 1'b0;
    checks += 3;
    if (busy1 !== 1'b0 || busy4 !== 1'b0) begin errors++; $display("FAIL reset_busy got %b%b want 00", busy1, busy4); end
    if (done1 !== 1'b0 || done4 !== 1'b0) begin errors++; $display("FAIL reset_done got %b%b want 00", done1, done4); end
    if (result1 !== 32'h0 || result4 !== 32'h0) begin errors++; $display("FAIL reset_result got %h %h want 0", result1, result4); end
    sel4 = 1'b0;
    do_op(16'd5, 16'd7, 1'b0, 1'b0, 17, "pre_reset");
    op_a = 16'd9; op_b = 16'd9; start = 1'b1;
    cycle();
    start = 1'b0;
    repeat (5) cycle();
    sys_rst = 1'b1;
    cycle(); cycle();
    sys_rst = 1'b0;
    model1 = '0; model4 = '0;
    checks += 3;
    if (busy1 !== 1'b0) begin errors++; $display("FAIL midreset_busy got %b want 0", busy1); end
    if (done1 !== 1'b0) begin errors++; $display("FAIL midreset_done got %b want 0", done1); end
    if (result1 !== 32'h0) begin errors++; $display("FAIL midreset_result got %h want 0", result1); end
    count_dones(25, cnt);
    checks++;
    if (cnt != 0) begin errors++; $display("FAIL midreset_late_done got %0d want 0", cnt); end
  endtask

  task automatic test_signed();
    sel4 = 1'b0;
    do_op(16'hFFFD, 16'd7, 1'b1, 1'b0, 17, "signed_m3x7");
    checks++;
    if (result1 !== 32'hFFFFFFEB) begin errors++; $display("FAIL signed_const got %h want ffffffeb", result1); end
  endtask

  task automatic test_extremes();
    sel4 = 1'b0;
    do_op(16'h8000, 16'h8000, 1'b1, 1'b0, 17, "signed_min");
    checks++;
    if (result1 !== 32'h40000000) begin errors++; $display("FAIL signed_min_const got %h want 40000000", result1); end
    do_op(16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 17, "unsigned_max");
    checks++;
    if (result1 !== 32'hFFFE0001) begin errors++; $display("FAIL unsigned_max_const got %h want fffe0001", result1); end
    do_op(16'h1234, 16'h0000, 1'b1, 1'b0, 17, "times_zero");
    do_op(16'h8000, 16'h7FFF, 1'b1, 1'b0, 17, "signed_min_x_max");
  endtask

  task automatic test_mac_chain();
    logic [15:0] av [3];
    logic [15:0] bv [3];
    logic        accv [3];
    logic [31:0] exp_r;
    int lat;
    av = '{16'd100, 16'd3, 16'hFFFB};
    bv = '{16'hFFFE, 16'd4, 16'hFFFB};
    accv = '{1'b0, 1'b1, 1'b1};
    sel4 = 1'b0;
    exp_r = model1;
    op_a = av[0]; op_b = bv[0]; is_signed = 1'b1; accumulate = accv[0]; start = 1'b1;
    for (int k = 0; k < 3; k++) begin
      exp_r = ref_mac(exp_r, av[k], bv[k], 1'b1, accv[k]);
      cycle();
      start = 1'b0;
      lat = 0;
      for (int i = 1; i <= 40; i++) begin
        cycle();
        if (done1 === 1'b1) begin lat = i; break; end
      end
      checks += 2;
      if (lat != 17) begin errors++; $display("FAIL chain%0d_latency got %0d want 17", k, lat); end
      if (result1 !== exp_r) begin errors++; $display("FAIL chain%0d_result got %h want %h", k, result1, exp_r); end
      if (k < 2) begin
        op_a = av[k+1]; op_b = bv[k+1]; accumulate = accv[k+1]; start = 1'b1;
      end
    end
    model1 = exp_r;
    checks++;
    if (result1 !== 32'hFFFFFF5D) begin errors++; $display("FAIL chain_final got %h want ffffff5d", result1); end
  endtask

  task automatic abort_at(input int j, input string name);
    int cnt;
    op_a = 16'd321; op_b = 16'd45; is_signed = 1'b0; accumulate = 1'b1; start = 1'b1;
    cycle();
    start = 1'b0;
    repeat (j) cycle();
    abort = 1'b1;
    cycle();
    abort = 1'b0;
    checks += 2;
    if (busy1 !== 1'b0) begin errors++; $display("FAIL %s_busy got %b want 0", name, busy1); end
    if (done1 !== 1'b0) begin errors++; $display("FAIL %s_done got %b want 0", name, done1); end
    count_dones(25, cnt);
    checks += 2;
    if (cnt != 0) begin errors++; $display("FAIL %s_late_done got %0d want 0", name, cnt); end
    if (result1 !== model1) begin errors++; $display("FAIL %s_held got %h want %h", name, result1, model1); end
  endtask

  task automatic test_handshake();
    logic [31:0] exp_r;
    int cnt, first;
    sel4 = 1'b0;
    exp_r = ref_mac(model1, 16'd1234, 16'hFFC8, 1'b1, 1'b0);
    op_a = 16'd1234; op_b = 16'hFFC8; is_signed = 1'b1; accumulate = 1'b0; start = 1'b1;
    cycle();
    start = 1'b0;
    cnt = 0; first = 0;
    for (int i = 1; i <= 40; i++) begin
      cycle();
      if (i == 3) begin start = 1'b1; op_a = 16'd777; op_b = 16'd3; is_signed = 1'b0; accumulate = 1'b1; end
      if (i == 4) start = 1'b0;
      if (i == 6) begin op_a = ~op_a; op_b = ~op_b; end
      if (i == 9) begin start = 1'b1; end
      if (i == 10) start = 1'b0;
      if (done1 === 1'b1) begin
        cnt++;
        if (first == 0) first = i;
      end
    end
    checks += 3;
    if (cnt != 1) begin errors++; $display("FAIL busy_start_dones got %0d want 1", cnt); end
    if (first != 17) begin errors++; $display("FAIL busy_start_latency got %0d want 17", first); end
    if (result1 !== exp_r) begin errors++; $display("FAIL busy_start_result got %h want %h", result1, exp_r); end
    model1 = exp_r;
    abort_at(5, "abort_calc");
    abort_at(16, "abort_fix");
    start = 1'b1; abort = 1'b1;
    cycle();
    start = 1'b0; abort = 1'b0;
    checks++;
    if (busy1 !== 1'b0) begin errors++; $display("FAIL abort_start_idle got busy %b want 0", busy1); end
    count_dones(25, cnt);
    checks++;
    if (cnt != 0) begin errors++; $display("FAIL abort_start_idle_done got %0d want 0", cnt); end
  endtask

  task automatic test_random_step4();
    logic [15:0] a, b;
    logic s, acc;
    sel4 = 1'b1;
    for (int n = 0; n < 10000; n++) begin
      a   = 16'($urandom);
      b   = 16'($urandom);
      s   = 1'($urandom);
      acc = 1'($urandom);
      do_op(a, b, s, acc, 5, "rand4");
    end
    sel4 = 1'b0;
  endtask

  initial begin
    @(negedge sys_clk);
    test_reset();
    test_signed();
    test_extremes();
    test_mac_chain();
    test_handshake();
    test_random_step4();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
